mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline: holds the EXE/MEM pipeline register, performs data-memory load/store over a req/ack handshake, and buffers pixel-memory writes in a small FIFO.
- Serves pixel-memory reads.
- Produces the MEM/WB register: regWrite, pcSrc, memToReg, Rd, dataMemRead, pixMemRead, aluResult, trigResult.
- Stalls upstream stages whenever it cannot accept a new instruction.

Parameters:
PIX_FIFO_DEPTH, 4, pixel write buffer entries (power of 2, >=2)
SCREEN_W, 320, pixels per row for address generation
SCREEN_H, 240, rows (used by optional clamp)
PIX_ADDR_W, 17, pixel address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
exe_valid  in  1  EXE stage presents an instruction
exe_regWrite, exe_pcSrc, exe_memWrite, exe_memPixWrite  in  1 each  control from EXE
exe_memToReg  in  2  00 alu, 01 data mem, 10 pixel mem, 11 trig
exe_Rd  in  4  destination register
exe_aluResult, exe_trigResult, exe_Ax, exe_Ay, exe_WD  in  32 each  EXE datapath
mem_stall  out  1  upstream must hold its outputs
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store
dmem_addr, dmem_wdata  out  32 each  address (aluResult) and store data (WD)
dmem_rdata  in  32  load data, valid with ack
dmem_ack  in  1  request complete
pix_wr_valid  out  1  FIFO head valid
pix_wr_ready  in  1  pixel memory accepts head
pix_wr_addr  out  PIX_ADDR_W  head address
pix_wr_data  out  32  head data
pix_rd_en  out  1  pixel read strobe
pix_rd_addr  out  PIX_ADDR_W  read address
pix_rd_data  in  32  read data, one cycle after pix_rd_en
wb_valid, wb_regWrite, wb_pcSrc  out  1 each  MEM/WB register
wb_memToReg  out  2  MEM/WB register
wb_Rd  out  4  MEM/WB register
wb_dataMemRead, wb_pixMemRead, wb_aluResult, wb_trigResult  out  32 each  MEM/WB register

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0, FIFO empty, FSM in IDLE, stage register invalid.
  - Reset mid-transaction abandons it; no store replay.
- Stage register:
  - Loads on a clk edge when exe_valid && !mem_stall.
  - Otherwise holds its value.
- Pixel address: pix_addr = Ay[15:0]*SCREEN_W + Ax[15:0], truncated to PIX_ADDR_W.
- FSM states and transitions:
  - IDLE, stage empty or instruction completes this cycle:
    - Non-memory op (memWrite=0, memPixWrite=0, memToReg in {00,11}) completes in one cycle.
    - MEM/WB is registered the next edge, so latency is 1 cycle.
  - IDLE, data op (memWrite=1 or memToReg=01): go to DMEM.
  - IDLE, memPixWrite=1: push {pix_addr, WD} to the FIFO and complete in one cycle if the FIFO is not full. If full, stay and stall.
  - IDLE, memToReg=10, FIFO not empty: go to DRAIN (read-after-write ordering).
  - IDLE, memToReg=10, FIFO empty: go to PRD.
  - DMEM:
    - dmem_req=1, with dmem_we/addr/wdata held stable until ack.
    - On dmem_ack, capture dmem_rdata (loads), complete, return to IDLE.
    - dmem_req drops the cycle after ack unless the next instruction is also a data op.
  - DRAIN: wait until the FIFO is empty, then go to PRD.
  - PRD:
    - pix_rd_en=1 for exactly one cycle.
    - Next cycle, capture pix_rd_data, complete, return to IDLE.
- mem_stall = stage valid && instruction not completing this cycle.
- FIFO:
  - Pops when pix_wr_valid && pix_wr_ready.
  - Push and pop in the same cycle are both allowed when full; count is unchanged.
  - Pointers wrap modulo PIX_FIFO_DEPTH.
- Completion and MEM/WB:
  - On completion, MEM/WB loads wb_valid=1 plus control and data.
  - Unused read fields load 0.
  - Without a completion, wb_valid=0 next cycle and the other wb fields hold.
- A bubble (exe_valid=0 with no stall) clears the stage register valid bit.
- Simultaneous dmem_ack and a new exe_valid: the new instruction is accepted on the same edge.

Optional Feature:
- Macro: PIX_ADDR_CLAMP_EN.
- When defined, Ax is clamped to [0, SCREEN_W-1] and Ay to [0, SCREEN_H-1] (signed compare) before address generation.
- When undefined, the raw truncated product is used and out-of-range coordinates wrap.

Test Plan:
- ALU op, Rd=3, aluResult=0x55, memToReg=00 -> wb_valid=1 next cycle, wb_aluResult=0x55, mem_stall never high.
- Load addr 0x100, dmem_ack after 3 cycles with rdata 0xDEADBEEF:
  - mem_stall high for 3 cycles.
  - wb_dataMemRead=0xDEADBEEF.
  - dmem_addr stable for all 3 cycles.
- 5 pixel writes, Ax=1..5, Ay=2, pix_wr_ready=0, depth 4:
  - 4 accepted, 5th stalls.
  - Raising ready drains addresses 641..645 in order.
- Pixel write to (10,0) then pixel read of (10,0):
  - Read waits until the FIFO is empty.
  - pix_rd_addr=10, wb_pixMemRead equals the returned data.
- rst_n low during DMEM wait -> dmem_req=0 and wb_valid=0 immediately; FIFO empty after release.
- Clamp build only: Ax=-5, Ay=300 -> pix_addr = 239*320 + 0 = 76480.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: EXE/MEM register, data-memory req/ack access, buffered pixel writes, pixel reads, MEM/WB register.
// Latency: non-memory ops and buffered pixel writes reach MEM/WB one cycle after the stage register loads;
//   loads/stores wait for dmem_ack; pixel reads take at least 3 cycles.
// Backpressure: mem_stall holds upstream while the stage instruction is not completing.
//   The pixel write FIFO drains on pix_wr_valid && pix_wr_ready.
// Ports: clk/rst_n; exe_* instruction from EXE; dmem_* data memory handshake;
//   pix_wr_* FIFO head toward pixel memory; pix_rd_* pixel read; wb_* MEM/WB register.
// Optional: define PIX_ADDR_CLAMP_EN to clamp Ax/Ay (signed) to the screen before address generation.
module mem_stage #(
  parameter int PIX_FIFO_DEPTH = 4,
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int PIX_ADDR_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exe_valid,
  input  logic                  exe_regWrite,
  input  logic                  exe_pcSrc,
  input  logic                  exe_memWrite,
  input  logic                  exe_memPixWrite,
  input  logic [1:0]            exe_memToReg,
  input  logic [3:0]            exe_Rd,
  input  logic [31:0]           exe_aluResult,
  input  logic [31:0]           exe_trigResult,
  input  logic [31:0]           exe_Ax,
  input  logic [31:0]           exe_Ay,
  input  logic [31:0]           exe_WD,
  output logic                  mem_stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  pix_wr_valid,
  input  logic                  pix_wr_ready,
  output logic [PIX_ADDR_W-1:0] pix_wr_addr,
  output logic [31:0]           pix_wr_data,
  output logic                  pix_rd_en,
  output logic [PIX_ADDR_W-1:0] pix_rd_addr,
  input  logic [31:0]           pix_rd_data,
  output logic                  wb_valid,
  output logic                  wb_regWrite,
  output logic                  wb_pcSrc,
  output logic [1:0]            wb_memToReg,
  output logic [3:0]            wb_Rd,
  output logic [31:0]           wb_dataMemRead,
  output logic [31:0]           wb_pixMemRead,
  output logic [31:0]           wb_aluResult,
  output logic [31:0]           wb_trigResult
);

  localparam int PTR_W = $clog2(PIX_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, DMEM, DRAIN, PRD, PRD_CAP} state_t;
  state_t state, next_state;

  // EXE/MEM stage register
  logic        s_valid, s_regWrite, s_pcSrc, s_memWrite, s_memPixWrite;
  logic [1:0]  s_memToReg;
  logic [3:0]  s_Rd;
  logic [31:0] s_alu, s_trig, s_Ax, s_Ay, s_WD;

  // Pixel write FIFO
  logic [PIX_ADDR_W-1:0] fifo_addr [PIX_FIFO_DEPTH];
  logic [31:0]           fifo_data [PIX_FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full, fifo_pop, fifo_push;

  logic complete, ld_dmem, ld_pix, req_c;
  logic [15:0] ax_c, ay_c;
  logic [PIX_ADDR_W-1:0] pix_addr;

`ifdef PIX_ADDR_CLAMP_EN
  always_comb begin
    ax_c = s_Ax[15:0];
    ay_c = s_Ay[15:0];
    if ($signed(s_Ax) < 0)                 ax_c = '0;
    else if ($signed(s_Ax) > SCREEN_W - 1) ax_c = 16'(SCREEN_W - 1);
    if ($signed(s_Ay) < 0)                 ay_c = '0;
    else if ($signed(s_Ay) > SCREEN_H - 1) ay_c = 16'(SCREEN_H - 1);
  end
`else
  // Raw coordinates: upper halves and the row count play no part in addressing.
  assign ax_c = s_Ax[15:0];
  assign ay_c = s_Ay[15:0];
  logic unused_hi;
  assign unused_hi = ^{s_Ax[31:16], s_Ay[31:16]};
  localparam int unused_screen_h = SCREEN_H;
`endif

  assign pix_addr = PIX_ADDR_W'(32'(ay_c) * 32'(SCREEN_W) + 32'(ax_c));

  assign fifo_full = (count == CNT_W'(PIX_FIFO_DEPTH));
  assign fifo_pop  = pix_wr_valid && pix_wr_ready;

  // Next state, completion and handshake strobes
  always_comb begin
    next_state = state;
    complete   = 1'b0;
    ld_dmem    = 1'b0;
    ld_pix     = 1'b0;
    req_c      = 1'b0;
    fifo_push  = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) begin
          if (s_memWrite || s_memToReg == 2'b01) begin
            // Request goes out straight away so back-to-back data ops keep dmem_req high.
            req_c = 1'b1;
            if (dmem_ack) begin
              complete = 1'b1;
              ld_dmem  = (s_memToReg == 2'b01);
            end else begin
              next_state = DMEM;
            end
          end else if (s_memPixWrite) begin
            // A full FIFO still takes the write if its head leaves this cycle.
            if (!fifo_full || fifo_pop) begin
              fifo_push = 1'b1;
              complete  = 1'b1;
            end
          end else if (s_memToReg == 2'b10) begin
            // Older buffered writes must land before the read.
            next_state = (count == '0) ? PRD : DRAIN;
          end else begin
            complete = 1'b1;
          end
        end
      end
      DMEM: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          complete   = 1'b1;
          ld_dmem    = (s_memToReg == 2'b01);
          next_state = IDLE;
        end
      end
      DRAIN:   if (count == '0) next_state = PRD;
      PRD:     next_state = PRD_CAP;
      PRD_CAP: begin
        complete   = 1'b1;
        ld_pix     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_stall   = s_valid && !complete;
  assign dmem_req    = req_c;
  assign dmem_we     = req_c && s_memWrite;
  assign dmem_addr   = req_c ? s_alu : '0;
  assign dmem_wdata  = req_c ? s_WD  : '0;
  assign pix_rd_en   = (state == PRD);
  assign pix_rd_addr = pix_addr;

  assign pix_wr_valid = (count != '0);
  assign pix_wr_addr  = pix_wr_valid ? fifo_addr[rd_ptr] : '0;
  assign pix_wr_data  = pix_wr_valid ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= 1'b0; s_regWrite <= 1'b0; s_pcSrc <= 1'b0;
      s_memWrite <= 1'b0; s_memPixWrite <= 1'b0; s_memToReg <= '0; s_Rd <= '0;
      s_alu <= '0; s_trig <= '0; s_Ax <= '0; s_Ay <= '0; s_WD <= '0;
    end else if (!mem_stall) begin
      s_valid <= exe_valid;  // a bubble clears the valid bit
      if (exe_valid) begin
        s_regWrite <= exe_regWrite; s_pcSrc <= exe_pcSrc;
        s_memWrite <= exe_memWrite; s_memPixWrite <= exe_memPixWrite;
        s_memToReg <= exe_memToReg; s_Rd <= exe_Rd;
        s_alu <= exe_aluResult; s_trig <= exe_trigResult;
        s_Ax <= exe_Ax; s_Ay <= exe_Ay; s_WD <= exe_WD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[wr_ptr] <= pix_addr;
      fifo_data[wr_ptr] <= s_WD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (fifo_push && !fifo_pop)      count <= count + 1'b1;
      else if (!fifo_push && fifo_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0; wb_regWrite <= 1'b0; wb_pcSrc <= 1'b0; wb_memToReg <= '0;
      wb_Rd <= '0; wb_dataMemRead <= '0; wb_pixMemRead <= '0;
      wb_aluResult <= '0; wb_trigResult <= '0;
    end else if (complete) begin
      wb_valid       <= 1'b1;
      wb_regWrite    <= s_regWrite;
      wb_pcSrc       <= s_pcSrc;
      wb_memToReg    <= s_memToReg;
      wb_Rd          <= s_Rd;
      wb_aluResult   <= s_alu;
      wb_trigResult  <= s_trig;
      wb_dataMemRead <= ld_dmem ? dmem_rdata  : '0;
      wb_pixMemRead  <= ld_pix  ? pix_rd_data : '0;
    end else begin
      wb_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valid, exe_regWrite, exe_pcSrc, exe_memWrite, exe_memPixWrite;
  logic [1:0]  exe_memToReg;
  logic [3:0]  exe_Rd;
  logic [31:0] exe_aluResult, exe_trigResult, exe_Ax, exe_Ay, exe_WD;
  logic        mem_stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        pix_wr_valid, pix_wr_ready, pix_rd_en;
  logic [16:0] pix_wr_addr, pix_rd_addr;
  logic [31:0] pix_wr_data, pix_rd_data;
  logic        wb_valid, wb_regWrite, wb_pcSrc;
  logic [1:0]  wb_memToReg;
  logic [3:0]  wb_Rd;
  logic [31:0] wb_dataMemRead, wb_pixMemRead, wb_aluResult, wb_trigResult;

  int checks = 0;
  int errors = 0;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .exe_valid(exe_valid), .exe_regWrite(exe_regWrite), .exe_pcSrc(exe_pcSrc),
    .exe_memWrite(exe_memWrite), .exe_memPixWrite(exe_memPixWrite),
    .exe_memToReg(exe_memToReg), .exe_Rd(exe_Rd),
    .exe_aluResult(exe_aluResult), .exe_trigResult(exe_trigResult),
    .exe_Ax(exe_Ax), .exe_Ay(exe_Ay), .exe_WD(exe_WD),
    .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pix_wr_valid(pix_wr_valid), .pix_wr_ready(pix_wr_ready),
    .pix_wr_addr(pix_wr_addr), .pix_wr_data(pix_wr_data),
    .pix_rd_en(pix_rd_en), .pix_rd_addr(pix_rd_addr), .pix_rd_data(pix_rd_data),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_pcSrc(wb_pcSrc),
    .wb_memToReg(wb_memToReg), .wb_Rd(wb_Rd),
    .wb_dataMemRead(wb_dataMemRead), .wb_pixMemRead(wb_pixMemRead),
    .wb_aluResult(wb_aluResult), .wb_trigResult(wb_trigResult)
  );

  always #5 clk = ~clk;

  // Pixel memory: returns a tagged word one cycle after the read strobe.
  always @(posedge clk) pix_rd_data <= pix_rd_en ? (32'hCAFE0000 | 32'(pix_rd_addr)) : 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exe();
    exe_valid = 0; exe_regWrite = 0; exe_pcSrc = 0; exe_memWrite = 0;
    exe_memPixWrite = 0; exe_memToReg = 0; exe_Rd = 0;
    exe_aluResult = 0; exe_trigResult = 0; exe_Ax = 0; exe_Ay = 0; exe_WD = 0;
  endtask

  initial begin
    rst_n = 0; clear_exe(); dmem_ack = 0; dmem_rdata = 0; pix_wr_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", mem_stall, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_pix_wr_valid", pix_wr_valid, 0);
    chk("rst_pix_rd_en", pix_rd_en, 0);
    rst_n = 1;
    step();

    // ALU op
    exe_valid = 1; exe_regWrite = 1; exe_Rd = 3; exe_aluResult = 32'h55; exe_trigResult = 32'h99;
    #1 chk("alu_stall_in", mem_stall, 0);
    step(); clear_exe();
    #1 chk("alu_stall_exec", mem_stall, 0);
    step();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_alu", wb_aluResult, 32'h55);
    chk("alu_wb_trig", wb_trigResult, 32'h99);
    chk("alu_wb_rd", wb_Rd, 3);
    chk("alu_wb_regwrite", wb_regWrite, 1);
    step();
    chk("alu_wb_valid_drop", wb_valid, 0);
    chk("alu_wb_alu_hold", wb_aluResult, 32'h55);

    // Load with a 3-cycle wait
    exe_valid = 1; exe_memToReg = 2'b01; exe_regWrite = 1; exe_Rd = 5; exe_aluResult = 32'h100;
    step(); clear_exe();
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("ld_stall", mem_stall, 1);
      chk("ld_req", dmem_req, 1);
      chk("ld_we", dmem_we, 0);
      chk("ld_addr", dmem_addr, 32'h100);
      step();
    end
    dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
    #1 chk("ld_ack_stall", mem_stall, 0);
    step(); dmem_ack = 0; dmem_rdata = 0;
    chk("ld_wb_valid", wb_valid, 1);
    chk("ld_wb_data", wb_dataMemRead, 32'hDEADBEEF);
    chk("ld_wb_pix", wb_pixMemRead, 0);
    chk("ld_wb_rd", wb_Rd, 5);
    chk("ld_req_drop", dmem_req, 0);

    // Back-to-back loads: ack and the next instruction on the same edge
    exe_valid = 1; exe_memToReg = 2'b01; exe_Rd = 1; exe_aluResult = 32'h300;
    step();
    exe_Rd = 2; exe_aluResult = 32'h304; dmem_ack = 1; dmem_rdata = 32'h11;
    #1;
    chk("b2b_stall", mem_stall, 0);
    chk("b2b_addr_a", dmem_addr, 32'h300);
    step(); clear_exe();
    chk("b2b_wb_a", wb_dataMemRead, 32'h11);
    chk("b2b_req_held", dmem_req, 1);
    chk("b2b_addr_b", dmem_addr, 32'h304);
    dmem_rdata = 32'h22;
    step(); dmem_ack = 0; dmem_rdata = 0;
    chk("b2b_wb_b", wb_dataMemRead, 32'h22);
    chk("b2b_wb_rd_b", wb_Rd, 2);
    chk("b2b_req_drop", dmem_req, 0);

    // Five pixel writes into a 4-deep FIFO with pixel memory not ready
    for (int i = 1; i <= 5; i++) begin
      exe_valid = 1; exe_memPixWrite = 1; exe_Ax = 32'(i); exe_Ay = 2; exe_WD = 32'h100 + 32'(i);
      #1 chk("pw_accept", mem_stall, 0);
      step();
    end
    clear_exe();
    #1;
    chk("pw_full_stall", mem_stall, 1);
    chk("pw_head_valid", pix_wr_valid, 1);
    chk("pw_head_addr", pix_wr_addr, 641);
    step();
    chk("pw_full_stall2", mem_stall, 1);
    pix_wr_ready = 1;
    #1 chk("pw_push_pop_full", mem_stall, 0);
    for (int i = 2; i <= 5; i++) begin
      step();
      chk("pw_drain_addr", pix_wr_addr, 17'(640 + i));
      chk("pw_drain_data", pix_wr_data, 32'h100 + 32'(i));
    end
    step();
    chk("pw_empty", pix_wr_valid, 0);
    pix_wr_ready = 0;

    // Pixel write then read of the same pixel
    exe_valid = 1; exe_memPixWrite = 1; exe_Ax = 10; exe_Ay = 0; exe_WD = 32'hABC;
    step();
    exe_memPixWrite = 0; exe_memToReg = 2'b10; exe_regWrite = 1; exe_Rd = 7; exe_WD = 0;
    step(); clear_exe();
    #1;
    chk("raw_stall", mem_stall, 1);
    chk("raw_no_rd", pix_rd_en, 0);
    chk("raw_head_addr", pix_wr_addr, 10);
    chk("raw_head_data", pix_wr_data, 32'hABC);
    step();
    chk("raw_drain_stall", mem_stall, 1);
    chk("raw_drain_no_rd", pix_rd_en, 0);
    pix_wr_ready = 1;
    step(); pix_wr_ready = 0;
    chk("raw_drained", pix_wr_valid, 0);
    chk("raw_wait_rd", pix_rd_en, 0);
    step();
    chk("raw_rd_en", pix_rd_en, 1);
    chk("raw_rd_addr", pix_rd_addr, 10);
    step();
    chk("raw_rd_once", pix_rd_en, 0);
    chk("raw_cap_stall", mem_stall, 0);
    step();
    chk("raw_wb_valid", wb_valid, 1);
    chk("raw_wb_pix", wb_pixMemRead, 32'hCAFE000A);
    chk("raw_wb_dmem", wb_dataMemRead, 0);
    chk("raw_wb_rd", wb_Rd, 7);
    chk("raw_wb_m2r", wb_memToReg, 2'b10);

    // Out-of-range coordinates
    exe_valid = 1; exe_memToReg = 2'b10; exe_Ax = 32'hFFFFFFFB; exe_Ay = 300;
    step(); clear_exe();
    step();
    chk("oor_rd_en", pix_rd_en, 1);
`ifdef PIX_ADDR_CLAMP_EN
    chk("oor_addr_clamp", pix_rd_addr, 76480);
`else
    chk("oor_addr_wrap", pix_rd_addr, 30459);
`endif
    step(); step();

    // Reset while a store waits on the data memory, with a buffered pixel write
    exe_valid = 1; exe_memPixWrite = 1; exe_Ax = 1; exe_Ay = 0; exe_WD = 32'h5;
    step();
    exe_memPixWrite = 0; exe_memWrite = 1; exe_aluResult = 32'h200; exe_WD = 32'h77;
    step(); clear_exe();
    #1;
    chk("st_wb_valid", wb_valid, 1);
    chk("st_req", dmem_req, 1);
    chk("st_we", dmem_we, 1);
    chk("st_wdata", dmem_wdata, 32'h77);
    chk("st_fifo", pix_wr_valid, 1);
    rst_n = 0;
    #1;
    chk("arst_req", dmem_req, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_fifo", pix_wr_valid, 0);
    chk("arst_stall", mem_stall, 0);
    step(); step();
    rst_n = 1;
    step();
    chk("post_rst_fifo", pix_wr_valid, 0);
    chk("post_rst_req", dmem_req, 0);
    chk("post_rst_stall", mem_stall, 0);
    chk("post_rst_wb", wb_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
